pipe_hazard_ctrl: RTL and testbench

Parametrised hazard and pipeline-control unit for the five-stage core (IF, ID, EX, MEM, WB). It generates per-stage enable and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, and EX-stage operand forwarding selects. It also runs a halt-drain state machine and keeps saturating stall and flush counters. It adds load-use stalling, branch flushing, variable-latency memory stalls and orderly halt drain, none of which the current core has.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 7 +
 rtl/pipe_hazard_ctrl_if.sv | 27 ++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 14 +
 rtl/pipe_hazard_ctrl.sv | 73 +++++++
 tb/tb_pipe_hazard_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_pkg: shared FSM state and forwarding-select encodings for the hazard unit
package pipe_pkg;
  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_e;
  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline status in, stage controls and forwarding selects out
interface pipe_hazard_ctrl_if #(parameter int REG_AW = 3, parameter int CNT_W = 16);
  logic              id_valid, id_halt, id_rs_use, id_rt_use;
  logic [REG_AW-1:0] id_rs_addr, id_rt_addr, ex_rs_addr, ex_rt_addr;
  logic              ex_regwrite, ex_memread, mem_regwrite, wb_regwrite;
  logic [REG_AW-1:0] ex_wreg, mem_wreg, wb_wreg;
  logic              ex_redirect, imem_stall, dmem_stall;
  logic              pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic              ifid_flush, idex_flush;
  logic [1:0]        fwd_a, fwd_b;
  logic              halted, err;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;
  modport master (
    output id_valid, id_halt, id_rs_use, id_rt_use, id_rs_addr, id_rt_addr,
           ex_rs_addr, ex_rt_addr, ex_regwrite, ex_memread, mem_regwrite, wb_regwrite,
           ex_wreg, mem_wreg, wb_wreg, ex_redirect, imem_stall, dmem_stall,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           fwd_a, fwd_b, halted, err, stall_cnt, flush_cnt
  );
  modport slave (
    input  id_valid, id_halt, id_rs_use, id_rt_use, id_rs_addr, id_rt_addr,
           ex_rs_addr, ex_rt_addr, ex_regwrite, ex_memread, mem_regwrite, wb_regwrite,
           ex_wreg, mem_wreg, wb_wreg, ex_redirect, imem_stall, dmem_stall,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           fwd_a, fwd_b, halted, err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// sat_counter: counter that sticks at all-ones instead of wrapping
module sat_counter #(parameter int W = 16) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stage enables/flushes, EX forwarding, halt drain FSM and perf counters
module pipe_hazard_ctrl import pipe_pkg::*; #(
  parameter int REG_AW    = 3,
  parameter int DRAIN_CYC = 3,
  parameter int CNT_W     = 16
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  state_e          state_q;
  logic [DW-1:0]   drain_q;
  logic            halted_q, err_q;
  logic            run, drn, frz, lu, accept, pc_en;
  logic            stall_inc, flush_inc;
  assign run = state_q == ST_RUN;
  assign drn = state_q == ST_DRAIN;
  // anything that is neither RUN nor DRAIN (HALTED or a corrupt encoding) freezes
  assign frz = bus.dmem_stall | ~(run | drn);
  assign lu  = bus.id_valid & bus.ex_memread & bus.ex_regwrite &
               ((bus.id_rs_use & (bus.id_rs_addr == bus.ex_wreg)) |
                (bus.id_rt_use & (bus.id_rt_addr == bus.ex_wreg)));
  assign accept = run & bus.id_valid & bus.id_halt & ~bus.dmem_stall & ~bus.ex_redirect & ~lu;
  assign pc_en          = ~frz & run & (bus.ex_redirect | ~(lu | bus.imem_stall));
  assign bus.pc_en      = pc_en;
  assign bus.ifid_en    = ~frz & ~(run & ~bus.ex_redirect & lu);
  assign bus.idex_en    = ~frz;
  assign bus.exmem_en   = ~frz;
  assign bus.memwb_en   = ~frz;
  assign bus.ifid_flush = ~frz & (drn | (run & (bus.ex_redirect | (~lu & bus.imem_stall))));
  assign bus.idex_flush = ~frz & run & (bus.ex_redirect | lu);
  always_comb begin
    bus.fwd_a = (bus.mem_regwrite && bus.mem_wreg == bus.ex_rs_addr) ? FWD_EXMEM :
                (bus.wb_regwrite  && bus.wb_wreg  == bus.ex_rs_addr) ? FWD_MEMWB : FWD_RF;
    bus.fwd_b = (bus.mem_regwrite && bus.mem_wreg == bus.ex_rt_addr) ? FWD_EXMEM :
                (bus.wb_regwrite  && bus.wb_wreg  == bus.ex_rt_addr) ? FWD_MEMWB : FWD_RF;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= ST_RUN;
      drain_q  <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: if (accept) begin
          state_q <= ST_DRAIN;
          drain_q <= DW'(DRAIN_CYC - 1);
        end
        ST_DRAIN: begin
          if (bus.ex_redirect | (bus.id_halt & bus.id_valid)) err_q <= 1'b1;
          if (!bus.dmem_stall) begin
            if (drain_q == '0) begin
              state_q  <= ST_HALTED;
              halted_q <= 1'b1;
            end else drain_q <= drain_q - 1'b1;
          end
        end
        ST_HALTED: halted_q <= 1'b1;
        default: begin
          err_q   <= 1'b1;
          state_q <= ST_HALTED;
        end
      endcase
    end
  assign bus.halted = halted_q;
  assign bus.err    = err_q;
  assign stall_inc  = run & ~pc_en & ~bus.ex_redirect;
  assign flush_inc  = run & bus.ex_redirect;
  sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .rst_n(rst_n), .inc(stall_inc), .cnt(bus.stall_cnt));
  sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .rst_n(rst_n), .inc(flush_inc), .cnt(bus.flush_cnt));
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios plus randomized run against a behavioural model
module tb_pipe_hazard_ctrl;
  localparam int AW = 3;
  localparam int CW = 4;
  localparam int DC = 3;
  localparam int SAT = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  pipe_hazard_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) bus ();
  pipe_hazard_ctrl #(.REG_AW(AW), .DRAIN_CYC(DC), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic clr_inputs();
    bus.id_valid = 0; bus.id_halt = 0; bus.id_rs_use = 0; bus.id_rt_use = 0;
    bus.id_rs_addr = 0; bus.id_rt_addr = 0; bus.ex_rs_addr = 0; bus.ex_rt_addr = 0;
    bus.ex_regwrite = 0; bus.ex_memread = 0; bus.mem_regwrite = 0; bus.wb_regwrite = 0;
    bus.ex_wreg = 0; bus.mem_wreg = 0; bus.wb_wreg = 0;
    bus.ex_redirect = 0; bus.imem_stall = 0; bus.dmem_stall = 0;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst_n = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    clr_inputs();
    rst_n = 0;
    @(negedge clk);
    checks++;
    if ({bus.halted, bus.err, bus.stall_cnt, bus.flush_cnt} !== '0) begin
      errors++; $display("FAIL reset_regs: got h=%b e=%b s=%0d f=%0d want all 0", bus.halted, bus.err, bus.stall_cnt, bus.flush_cnt);
    end
    checks++;
    if ({bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en, bus.ifid_flush, bus.idex_flush} !== 7'b1111100) begin
      errors++; $display("FAIL reset_decode: got %b want 1111100", {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en, bus.ifid_flush, bus.idex_flush});
    end
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    checks++;
    if ({bus.halted, bus.err, bus.stall_cnt, bus.flush_cnt, bus.pc_en} !== {2'b00, 8'h00, 1'b1}) begin
      errors++; $display("FAIL reset_release: got h=%b e=%b s=%0d f=%0d pc=%b", bus.halted, bus.err, bus.stall_cnt, bus.flush_cnt, bus.pc_en);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    do_reset();
    bus.id_valid = 1; bus.id_rs_use = 1; bus.id_rs_addr = 2;
    bus.ex_memread = 1; bus.ex_regwrite = 1; bus.ex_wreg = 2;
    @(negedge clk);
    checks++;
    if ({bus.pc_en, bus.ifid_en, bus.idex_flush, bus.idex_en} !== 4'b0011) begin
      errors++; $display("FAIL load_use_stall: got pc=%b ifid=%b idf=%b idex=%b want 0 0 1 1", bus.pc_en, bus.ifid_en, bus.idex_flush, bus.idex_en);
    end
    @(posedge clk); #1;
    bus.ex_memread = 0; bus.ex_regwrite = 0; bus.ex_wreg = 0; bus.ex_rs_addr = 2;
    bus.mem_regwrite = 1; bus.mem_wreg = 2;
    @(negedge clk);
    checks++;
    if ({bus.pc_en, bus.idex_flush, bus.fwd_a} !== 4'b1001) begin
      errors++; $display("FAIL load_use_next: got pc=%b idf=%b fwd_a=%0d want 1 0 1", bus.pc_en, bus.idex_flush, bus.fwd_a);
    end
    checks++;
    if (bus.stall_cnt !== 4'd1) begin
      errors++; $display("FAIL load_use_cnt: got %0d want 1", bus.stall_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_forwarding();
    do_reset();
    bus.mem_wreg = 5; bus.wb_wreg = 5; bus.mem_regwrite = 1; bus.wb_regwrite = 1;
    bus.ex_rs_addr = 5; bus.ex_rt_addr = 5;
    #1;
    checks++;
    if ({bus.fwd_a, bus.fwd_b} !== 4'b0101) begin
      errors++; $display("FAIL fwd_exmem: got a=%0d b=%0d want 1 1", bus.fwd_a, bus.fwd_b);
    end
    bus.mem_regwrite = 0;
    #1;
    checks++;
    if ({bus.fwd_a, bus.fwd_b} !== 4'b1010) begin
      errors++; $display("FAIL fwd_memwb: got a=%0d b=%0d want 2 2", bus.fwd_a, bus.fwd_b);
    end
    bus.ex_rs_addr = 4;
    #1;
    checks++;
    if ({bus.fwd_a, bus.fwd_b} !== 4'b0010) begin
      errors++; $display("FAIL fwd_rf: got a=%0d b=%0d want 0 2", bus.fwd_a, bus.fwd_b);
    end
    bus.wb_wreg = 0; bus.ex_rt_addr = 0;
    #1;
    checks++;
    if (bus.fwd_b !== 2'd2) begin
      errors++; $display("FAIL fwd_r0: got b=%0d want 2", bus.fwd_b);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_redirect_priority();
    do_reset();
    bus.id_valid = 1; bus.id_rt_use = 1; bus.id_rt_addr = 3;
    bus.ex_memread = 1; bus.ex_regwrite = 1; bus.ex_wreg = 3;
    bus.imem_stall = 1; bus.ex_redirect = 1; bus.id_halt = 1;
    @(negedge clk);
    checks++;
    if ({bus.pc_en, bus.ifid_flush, bus.idex_flush} !== 3'b111) begin
      errors++; $display("FAIL redirect_prio: got pc=%b iff=%b idf=%b want 1 1 1", bus.pc_en, bus.ifid_flush, bus.idex_flush);
    end
    @(posedge clk); #1;
    clr_inputs();
    @(negedge clk);
    checks++;
    if ({bus.flush_cnt, bus.stall_cnt, bus.pc_en, bus.halted} !== {4'd1, 4'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL redirect_cnt: got f=%0d s=%0d pc=%b h=%b want 1 0 1 0", bus.flush_cnt, bus.stall_cnt, bus.pc_en, bus.halted);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_halt_drain();
    do_reset();
    bus.id_valid = 1; bus.id_halt = 1;
    @(negedge clk);
    checks++;
    if (bus.pc_en !== 1'b1) begin
      errors++; $display("FAIL halt_accept_pc: got %b want 1", bus.pc_en);
    end
    @(posedge clk); #1;
    clr_inputs();
    for (int k = 1; k <= 6; k++) begin
      bus.dmem_stall = (k == 2 || k == 3);
      @(negedge clk);
      checks++;
      if (bus.pc_en !== 1'b0 || bus.halted !== (k == 6)) begin
        errors++; $display("FAIL halt_drain_%0d: got pc=%b h=%b want 0 %b", k, bus.pc_en, bus.halted, k == 6);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if ({bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en, bus.halted, bus.err} !== 6'b000010) begin
      errors++; $display("FAIL halted_hold: got %b want 000010", {bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en, bus.halted, bus.err});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_err();
    do_reset();
    bus.id_valid = 1; bus.id_halt = 1;
    @(posedge clk); #1;
    clr_inputs();
    bus.ex_redirect = 1;
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b0 || bus.pc_en !== 1'b0) begin
      errors++; $display("FAIL err_pre: got err=%b pc=%b want 0 0", bus.err, bus.pc_en);
    end
    @(posedge clk); #1;
    bus.ex_redirect = 0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.err !== 1'b1) begin
        errors++; $display("FAIL err_sticky: got %b want 1", bus.err);
      end
      @(posedge clk); #1;
    end
    rst_n = 0;
    #1;
    checks++;
    if ({bus.err, bus.halted, bus.stall_cnt, bus.flush_cnt, bus.pc_en} !== {2'b00, 8'h00, 1'b1}) begin
      errors++; $display("FAIL err_reset: got e=%b h=%b s=%0d f=%0d pc=%b", bus.err, bus.halted, bus.stall_cnt, bus.flush_cnt, bus.pc_en);
    end
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_saturation();
    do_reset();
    bus.id_valid = 1; bus.id_rs_use = 1; bus.id_rs_addr = 6;
    bus.ex_memread = 1; bus.ex_regwrite = 1; bus.ex_wreg = 6;
    for (int n = 1; n <= (1 << CW) + 3; n++) begin
      @(posedge clk); #1;
      if (n == 10) begin
        checks++;
        if (bus.stall_cnt !== 4'd10) begin
          errors++; $display("FAIL sat_mid: got %0d want 10", bus.stall_cnt);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (bus.stall_cnt !== 4'(SAT)) begin
      errors++; $display("FAIL sat_top: got %0d want %0d", bus.stall_cnt, SAT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int mode, rem, m_stall, m_flush;
    bit m_err, lu, accept;
    logic e_pc, e_ifid, e_rest, e_iff, e_idf;
    logic [1:0] e_fa, e_fb;
    mode = 0; rem = 0; m_stall = 0; m_flush = 0; m_err = 0;
    for (int n = 0; n < 600; n++) begin
      if (n % 60 == 0) begin
        do_reset();
        mode = 0; rem = 0; m_stall = 0; m_flush = 0; m_err = 0;
      end
      bus.id_valid = 1'($urandom_range(0, 1)); bus.id_halt = ($urandom_range(0, 9) == 0);
      bus.id_rs_use = 1'($urandom_range(0, 1)); bus.id_rt_use = 1'($urandom_range(0, 1));
      bus.id_rs_addr = 3'($urandom_range(0, 3)); bus.id_rt_addr = 3'($urandom_range(0, 3));
      bus.ex_rs_addr = 3'($urandom_range(0, 3)); bus.ex_rt_addr = 3'($urandom_range(0, 3));
      bus.ex_wreg = 3'($urandom_range(0, 3)); bus.mem_wreg = 3'($urandom_range(0, 3)); bus.wb_wreg = 3'($urandom_range(0, 3));
      bus.ex_regwrite = 1'($urandom_range(0, 1)); bus.ex_memread = 1'($urandom_range(0, 1));
      bus.mem_regwrite = 1'($urandom_range(0, 1)); bus.wb_regwrite = 1'($urandom_range(0, 1));
      bus.ex_redirect = ($urandom_range(0, 5) == 0); bus.imem_stall = ($urandom_range(0, 3) == 0);
      bus.dmem_stall = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      lu = bus.id_valid && bus.ex_memread && bus.ex_regwrite &&
           ((bus.id_rs_use && bus.id_rs_addr == bus.ex_wreg) || (bus.id_rt_use && bus.id_rt_addr == bus.ex_wreg));
      e_pc = 1; e_ifid = 1; e_rest = 1; e_iff = 0; e_idf = 0;
      if (mode == 2 || bus.dmem_stall) begin e_pc = 0; e_ifid = 0; e_rest = 0; end
      else if (mode == 1) begin e_pc = 0; e_iff = 1; end
      else if (bus.ex_redirect) begin e_iff = 1; e_idf = 1; end
      else if (lu) begin e_pc = 0; e_ifid = 0; e_idf = 1; end
      else if (bus.imem_stall) begin e_pc = 0; e_iff = 1; end
      e_fa = (bus.mem_regwrite && bus.mem_wreg == bus.ex_rs_addr) ? 2'd1 : (bus.wb_regwrite && bus.wb_wreg == bus.ex_rs_addr) ? 2'd2 : 2'd0;
      e_fb = (bus.mem_regwrite && bus.mem_wreg == bus.ex_rt_addr) ? 2'd1 : (bus.wb_regwrite && bus.wb_wreg == bus.ex_rt_addr) ? 2'd2 : 2'd0;
      checks++;
      if ({bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en, bus.ifid_flush, bus.idex_flush, bus.fwd_a, bus.fwd_b} !==
          {e_pc, e_ifid, e_rest, e_rest, e_rest, e_iff, e_idf, e_fa, e_fb}) begin
        errors++; $display("FAIL rand_ctrl[%0d]: got %b want %b", n,
          {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en, bus.ifid_flush, bus.idex_flush, bus.fwd_a, bus.fwd_b},
          {e_pc, e_ifid, e_rest, e_rest, e_rest, e_iff, e_idf, e_fa, e_fb});
      end
      checks++;
      if ({bus.halted, bus.err, bus.stall_cnt, bus.flush_cnt} !== {mode == 2, m_err, 4'(m_stall), 4'(m_flush)}) begin
        errors++; $display("FAIL rand_regs[%0d]: got h=%b e=%b s=%0d f=%0d want h=%b e=%b s=%0d f=%0d", n,
          bus.halted, bus.err, bus.stall_cnt, bus.flush_cnt, mode == 2, m_err, m_stall, m_flush);
      end
      if (mode == 0) begin
        if (bus.ex_redirect && m_flush < SAT) m_flush++;
        if (!e_pc && !bus.ex_redirect && m_stall < SAT) m_stall++;
        accept = bus.id_valid && bus.id_halt && !bus.dmem_stall && !bus.ex_redirect && !lu;
        if (accept) begin mode = 1; rem = DC - 1; end
      end else if (mode == 1) begin
        if (bus.ex_redirect || (bus.id_halt && bus.id_valid)) m_err = 1;
        if (!bus.dmem_stall) begin
          if (rem == 0) mode = 2;
          else rem--;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    clr_inputs();
    test_reset();
    test_load_use();
    test_forwarding();
    test_redirect_priority();
    test_halt_drain();
    test_err();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
